// File: rtl/barrier_pkg.sv
// Shared definitions for the ring barrier controller.
//   MSG_ENTER / MSG_RELEASE : barrier message codes
//   state_t                 : barrier sequencer state encoding
//   is_barrier_pkt()        : decoded packet belongs to this node's barrier
package barrier_pkg;

  localparam logic [15:0] MSG_ENTER   = 16'h0001;
  localparam logic [15:0] MSG_RELEASE = 16'h0002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HAVE_LOCAL,
    ST_HAVE_TOKEN,
    ST_SEND_ENTER,
    ST_WAIT_RETURN,
    ST_SEND_RELEASE,
    ST_WAIT_RELEASE
  } state_t;

  // A packet is ours only when flagged barrier (and not contradicted) and
  // addressed to our communicator; everything else is passed through.
  function automatic logic is_barrier_pkt(input logic        barrier_pkt,
                                          input logic        not_barrier_pkt,
                                          input logic [15:0] rx_comm_id,
                                          input logic [15:0] cfg_comm_id);
    return barrier_pkt && !not_barrier_pkt && (rx_comm_id == cfg_comm_id);
  endfunction

  function automatic logic is_send(input state_t s);
    return (s == ST_SEND_ENTER) || (s == ST_SEND_RELEASE);
  endfunction

endpackage

// File: rtl/barrier_tx_req_hold.sv
// Request/ack hold register toward the packet generator.
//   clk, reset       : clock, synchronous active-high reset
//   load             : capture a new request (message + comm id), raise tx_req
//   load_message/_comm_id : request payload captured on load
//   tx_ack           : generator accepted; drops tx_req on the next edge
//   tx_req/tx_message/tx_comm_id : registered request, payload stable while tx_req
module barrier_tx_req_hold (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_message,
  input  logic [15:0] load_comm_id,
  input  logic        tx_ack,
  output logic        tx_req,
  output logic [15:0] tx_message,
  output logic [15:0] tx_comm_id
);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_req     <= 1'b0;
      tx_message <= '0;
      tx_comm_id <= '0;
    end else if (load) begin
      tx_req     <= 1'b1;
      tx_message <= load_message;
      tx_comm_id <= load_comm_id;
    end else if (tx_req && tx_ack) begin
      // payload is left as-is so it never glitches around the ack
      tx_req <= 1'b0;
    end
  end

endmodule

// File: rtl/barrier_ring_ctrl.sv
// Per-node ring barrier sequencer.
// Consumes decoder results, runs ENTER/RELEASE token circulation, drives
// send requests to the packet generator and consume/pass verdicts.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   decode_done, barrier_pkt, not_barrier_pkt, rx_message, rx_comm_id : decode
//   cfg_comm_id, cfg_is_root  : node config, sampled only while IDLE
//   host_enter / host_release : host handshake pulses
//   tx_req, tx_message, tx_comm_id, tx_ack : generator request/ack
//   pkt_consume / pkt_pass    : per-packet verdict, one cycle after decode_done
//   barrier_busy              : state != IDLE
//   err_unexpected            : protocol violation pulse
//   timeout_err               : root ENTER-return timeout pulse
// Optional: define BARRIER_TIMEOUT_EN to enable the root return timeout and
// token re-send; otherwise timeout_err is tied 0.
module barrier_ring_ctrl
  import barrier_pkg::*;
#(
  parameter int unsigned           CNT_WIDTH      = 24,
  parameter logic [CNT_WIDTH-1:0]  TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        decode_done,
  input  logic        barrier_pkt,
  input  logic        not_barrier_pkt,
  input  logic [15:0] rx_message,
  input  logic [15:0] rx_comm_id,
  input  logic [15:0] cfg_comm_id,
  input  logic        cfg_is_root,
  input  logic        host_enter,
  output logic        host_release,
  output logic        tx_req,
  output logic [15:0] tx_message,
  output logic [15:0] tx_comm_id,
  input  logic        tx_ack,
  output logic        pkt_consume,
  output logic        pkt_pass,
  output logic        barrier_busy,
  output logic        err_unexpected,
  output logic        timeout_err
);

  state_t      state, state_nxt;
  logic        root_q;
  logic [15:0] comm_q;
  logic        eff_root;
  logic [15:0] eff_comm;
  logic        match, rx_enter, rx_release, ack;
  logic        rx_ok, err_nxt, rel_nxt, timeout_hit, load;

  // Config is live while IDLE and frozen for the rest of the barrier.
  assign eff_root = (state == ST_IDLE) ? cfg_is_root : root_q;
  assign eff_comm = (state == ST_IDLE) ? cfg_comm_id : comm_q;

  assign match      = decode_done && is_barrier_pkt(barrier_pkt, not_barrier_pkt,
                                                    rx_comm_id, eff_comm);
  assign rx_enter   = match && (rx_message == MSG_ENTER);
  assign rx_release = match && (rx_message == MSG_RELEASE);
  assign ack        = tx_ack && tx_req;

`ifdef BARRIER_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMER_LAST = TIMEOUT_CYCLES - 1'b1;
  logic [CNT_WIDTH-1:0] timer;

  assign timeout_hit = (state == ST_WAIT_RETURN) && (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset || state != ST_WAIT_RETURN || state_nxt != ST_WAIT_RETURN)
      timer <= '0;
    else
      timer <= timer + 1'b1;
  end

  // a token returning on the deadline cycle wins over the re-send
  always_ff @(posedge clk) begin
    if (reset) timeout_err <= 1'b0;
    else       timeout_err <= timeout_hit && !rx_enter;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      root_q <= 1'b0;
      comm_q <= '0;
    end else begin
      state  <= state_nxt;
      root_q <= eff_root;
      comm_q <= eff_comm;
    end
  end

  always_comb begin
    state_nxt = state;
    rx_ok     = 1'b0;   // matching packet was legal in this state
    rel_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (eff_root) begin
          if (host_enter) state_nxt = ST_SEND_ENTER;
        end else if (host_enter && rx_enter) begin
          state_nxt = ST_SEND_ENTER;
          rx_ok     = 1'b1;
        end else if (host_enter) begin
          state_nxt = ST_HAVE_LOCAL;
        end else if (rx_enter) begin
          state_nxt = ST_HAVE_TOKEN;
          rx_ok     = 1'b1;
        end
      end
      ST_HAVE_LOCAL: if (rx_enter) begin
        state_nxt = ST_SEND_ENTER;
        rx_ok     = 1'b1;
      end
      ST_HAVE_TOKEN: if (host_enter) state_nxt = ST_SEND_ENTER;
      ST_SEND_ENTER: if (ack) state_nxt = eff_root ? ST_WAIT_RETURN : ST_WAIT_RELEASE;
      ST_WAIT_RETURN: begin
        if (rx_enter) begin
          state_nxt = ST_SEND_RELEASE;
          rx_ok     = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = ST_SEND_ENTER;
        end
      end
      ST_SEND_RELEASE: if (ack) begin
        if (eff_root) begin
          state_nxt = ST_WAIT_RELEASE;
        end else begin
          state_nxt = ST_IDLE;
          rel_nxt   = 1'b1;
        end
      end
      ST_WAIT_RELEASE: if (rx_release) begin
        rx_ok = 1'b1;
        if (eff_root) begin
          state_nxt = ST_IDLE;
          rel_nxt   = 1'b1;
        end else begin
          state_nxt = ST_SEND_RELEASE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    err_nxt = (match && !rx_ok) ||
              (host_enter && state != ST_IDLE && state != ST_HAVE_TOKEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_consume    <= 1'b0;
      pkt_pass       <= 1'b0;
      err_unexpected <= 1'b0;
      host_release   <= 1'b0;
    end else begin
      pkt_consume    <= match;
      pkt_pass       <= decode_done && !match;
      err_unexpected <= err_nxt;
      host_release   <= rel_nxt;
    end
  end

  assign barrier_busy = (state != ST_IDLE);

  // Load only on entry into a SEND state so tx_req rises once per send.
  assign load = is_send(state_nxt) && (state_nxt != state);

  barrier_tx_req_hold u_tx_hold (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_message ((state_nxt == ST_SEND_ENTER) ? MSG_ENTER : MSG_RELEASE),
    .load_comm_id (eff_comm),
    .tx_ack       (tx_ack),
    .tx_req       (tx_req),
    .tx_message   (tx_message),
    .tx_comm_id   (tx_comm_id)
  );

endmodule
